adc_sample_scheduler: RTL and testbench

Sequences conversions of the serial 8-bit ADC driver at a programmable sample rate, averages blocks of 2^AVG_LOG2 samples, and tracks running minimum/maximum for display. It sits between the ADC driver (start/done handshake) and the BCD/seven-segment path, and adds timeout and overrun supervision.

---
 rtl/adc_sample_scheduler.sv | 256 +++++++++++++++++++++++++
 tb/tb_adc_sample_scheduler.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_scheduler.sv
// -----------------------------------------------------------------------------
// adc_sample_scheduler
//
// Paces conversions of the serial 8-bit ADC driver at a fixed sample rate,
// averages blocks of 2^AVG_LOG2 samples and tracks the running min/max of the
// raw samples for display. A conversion that never completes is abandoned
// after TIMEOUT cycles, and a sample tick that lands while a conversion is
// still in flight is dropped and flagged.
//
// Parameters
//   SAMPLE_DIV  clock cycles between sample ticks (>= 4)
//   AVG_LOG2    log2 of samples per average block (0..6)
//   TIMEOUT     maximum cycles spent waiting for i_done after o_start
//
// Ports
//   i_clk          system clock
//   i_rst          synchronous, active-high reset
//   i_enable       level, enables sampling; low abandons any work in progress
//   i_hold         level, freezes o_avg/o_min/o_max and suppresses o_valid
//   i_clr_minmax   pulse, reinitialises min/max
//   i_clr_err      pulse, clears the sticky error flags
//   o_start        one-cycle conversion request to the ADC driver
//   i_done         one-cycle completion pulse; i_data valid on this cycle
//   i_data         conversion result
//   o_avg          last published block average
//   o_min / o_max  min/max raw sample since the last clear
//   o_valid        one-cycle pulse when o_avg updates
//   o_timeout_err  sticky, a conversion timed out
//   o_overrun      sticky, a tick arrived while a conversion was in flight
// -----------------------------------------------------------------------------
module adc_sample_scheduler #(
  parameter int SAMPLE_DIV = 50000,
  parameter int AVG_LOG2   = 3,
  parameter int TIMEOUT    = 2000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_enable,
  input  logic       i_hold,
  input  logic       i_clr_minmax,
  input  logic       i_clr_err,
  output logic       o_start,
  input  logic       i_done,
  input  logic [7:0] i_data,
  output logic [7:0] o_avg,
  output logic [7:0] o_min,
  output logic [7:0] o_max,
  output logic       o_valid,
  output logic       o_timeout_err,
  output logic       o_overrun
);

  localparam int TICK_W = $clog2(SAMPLE_DIV);
  localparam int TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int ACC_W  = 8 + AVG_LOG2;   // wide enough for a full block of 8'hFF
  localparam int CNT_W  = AVG_LOG2 + 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_START,
    S_CONVERT
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [TICK_W-1:0]  r_tick_cnt;
  logic               r_tick;
  logic [TO_W-1:0]    r_to_cnt;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_count;
  logic [7:0]         r_avg;
  logic [7:0]         r_min;
  logic [7:0]         r_max;
  logic               r_valid;
  logic               r_timeout_err;
  logic               r_overrun;

  logic               w_start;
  logic               w_accept;
  logic               w_timeout;
  logic               w_overrun;
  logic [ACC_W-1:0]   w_sum;

  // ---------------------------------------------------------------------------
  // Sample tick. Registered, so it is visible the cycle after the counter
  // wraps; that extra cycle is what puts the first o_start SAMPLE_DIV+1
  // cycles after enable while keeping start-to-start spacing at SAMPLE_DIV.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is always written with non-blocking (<=) so every
  // flop samples the pre-edge value of every other flop, independent of the
  // order in which the simulator evaluates the always blocks.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_enable) begin
      r_tick_cnt <= '0;
      r_tick     <= 1'b0;
    end else if (r_tick_cnt == TICK_LAST) begin
      r_tick_cnt <= '0;
      r_tick     <= 1'b1;
    end else begin
      r_tick_cnt <= r_tick_cnt + TICK_W'(1);
      r_tick     <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Conversion FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Conversion FSM: next state and per-cycle strobes. Dropping i_enable wins
  // over everything, which is also what makes a late i_done harmless: the FSM
  // is no longer in CONVERT when it arrives.
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_accept    = 1'b0;
    w_timeout   = 1'b0;
    w_overrun   = 1'b0;

    if (!i_enable) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_WAIT;
        end
        S_WAIT: begin
          if (r_tick) w_state_nxt = S_START;
        end
        S_START: begin
          w_start     = 1'b1;
          w_overrun   = r_tick;
          w_state_nxt = S_CONVERT;
        end
        S_CONVERT: begin
          // A tick here is dropped, not queued; only the flag remembers it.
          w_overrun = r_tick;
          if (i_done) begin
            w_accept    = 1'b1;
            w_state_nxt = S_WAIT;
          end else if (r_to_cnt == TO_LAST) begin
            w_timeout   = 1'b1;
            w_state_nxt = S_WAIT;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Timeout counter: zeroed in START, so it reads 0 on the first CONVERT
  // cycle and reaches TIMEOUT-1 on the TIMEOUT-th one.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_enable || r_state == S_START) begin
      r_to_cnt <= '0;
    end else if (r_state == S_CONVERT) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Averaging, min/max and sticky flags
  // ---------------------------------------------------------------------------
  assign w_sum = r_acc + ACC_W'(i_data);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc         <= '0;
      r_count       <= '0;
      r_avg         <= 8'h00;
      r_min         <= 8'hFF;
      r_max         <= 8'h00;
      r_valid       <= 1'b0;
      r_timeout_err <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_valid <= 1'b0;

      // Partial sums never survive a disable, so re-enabling starts a clean block.
      if (!i_enable) begin
        r_acc   <= '0;
        r_count <= '0;
      end else if (w_accept) begin
        if (r_count == CNT_LAST) begin
          r_acc   <= '0;
          r_count <= '0;
          // A block completing under hold is still consumed, just not published.
          if (!i_hold) begin
            r_avg   <= w_sum[AVG_LOG2 +: 8];
            r_valid <= 1'b1;
          end
        end else begin
          r_acc   <= w_sum;
          r_count <= r_count + CNT_W'(1);
        end
      end

      // A clear that coincides with a published sample restarts min/max at
      // that sample rather than at FF/00, so the sample is not lost.
      if (w_accept && !i_hold) begin
        if (i_clr_minmax) begin
          r_min <= i_data;
          r_max <= i_data;
        end else begin
          if (i_data < r_min) r_min <= i_data;
          if (i_data > r_max) r_max <= i_data;
        end
      end else if (i_clr_minmax) begin
        r_min <= 8'hFF;
        r_max <= 8'h00;
      end

      // Set takes priority over clear so a coincident event is never lost.
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end else if (i_clr_err) begin
        r_timeout_err <= 1'b0;
      end

      if (w_overrun) begin
        r_overrun <= 1'b1;
      end else if (i_clr_err) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign o_start       = w_start;
  assign o_avg         = r_avg;
  assign o_min         = r_min;
  assign o_max         = r_max;
  assign o_valid       = r_valid;
  assign o_timeout_err = r_timeout_err;
  assign o_overrun     = r_overrun;

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// -----------------------------------------------------------------------------
// tb_adc_sample_scheduler
//
// Directed bench for adc_sample_scheduler with SAMPLE_DIV=10, AVG_LOG2=2,
// TIMEOUT=20. A small ADC-driver model answers each o_start with i_done after
// a chosen delay. Inputs change and outputs are sampled 1 time unit after the
// rising edge; every expected value below is worked out by hand.
// -----------------------------------------------------------------------------
module tb_adc_sample_scheduler;

  localparam int SD  = 10;
  localparam int AL  = 2;
  localparam int TO  = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       hold;
  logic       clr_mm;
  logic       clr_err;
  logic       start;
  logic       done;
  logic [7:0] data;
  logic [7:0] avg;
  logic [7:0] mn;
  logic [7:0] mx;
  logic       valid;
  logic       to_err;
  logic       ovr;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  adc_sample_scheduler #(
    .SAMPLE_DIV (SD),
    .AVG_LOG2   (AL),
    .TIMEOUT    (TO)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_enable      (en),
    .i_hold        (hold),
    .i_clr_minmax  (clr_mm),
    .i_clr_err     (clr_err),
    .o_start       (start),
    .i_done        (done),
    .i_data        (data),
    .o_avg         (avg),
    .o_min         (mn),
    .o_max         (mx),
    .o_valid       (valid),
    .o_timeout_err (to_err),
    .o_overrun     (ovr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Returns the cycle on which o_start is seen (immediately if already high).
  task automatic wait_start(output int sc);
    for (int k = 0; k < 60 && !start; k++) step();
    if (!start) check("start_seen", 32'(start), 32'd1);
    sc = cyc;
  endtask

  // Driver model: i_done arrives dly cycles after o_start, optionally with a
  // simultaneous min/max clear. Returns with the accepted sample visible.
  task automatic conv(input int dly, input int d, input bit clr, output int sc);
    wait_start(sc);
    repeat (dly) step();
    done   = 1'b1;
    data   = 8'(d);
    clr_mm = clr;
    step();
    done   = 1'b0;
    data   = 8'h00;
    clr_mm = 1'b0;
  endtask

  task automatic check_pub(input string tag, input int e_avg, input int e_min, input int e_max);
    check({tag, "_valid"}, 32'(valid), 32'd1);
    check({tag, "_avg"},   32'(avg),   32'(e_avg));
    check({tag, "_min"},   32'(mn),    32'(e_min));
    check({tag, "_max"},   32'(mx),    32'(e_max));
  endtask

  initial begin
    int c0, s, s1, s2;

    rst = 1'b1; en = 1'b0; hold = 1'b0; clr_mm = 1'b0; clr_err = 1'b0;
    done = 1'b0; data = 8'h00;
    repeat (3) step();

    // ---- reset values --------------------------------------------------------
    check("rst_start",  32'(start),  32'd0);
    check("rst_valid",  32'(valid),  32'd0);
    check("rst_avg",    32'(avg),    32'd0);
    check("rst_min",    32'(mn),     32'hFF);
    check("rst_max",    32'(mx),     32'd0);
    check("rst_toerr",  32'(to_err), 32'd0);
    check("rst_ovr",    32'(ovr),    32'd0);
    rst = 1'b0;
    step();

    // ---- averaging: 10,20,30,41 -> 101>>2 = 25 -------------------------------
    en = 1'b1;
    c0 = cyc;
    wait_start(s1);
    check("first_start_latency", s1 - c0, SD + 1);
    step();
    check("start_one_cycle", 32'(start), 32'd0);
    step(); step();
    done = 1'b1; data = 8'd10; step(); done = 1'b0;
    conv(3, 20, 1'b0, s2);
    check("start_spacing", s2 - s1, SD);
    conv(3, 30, 1'b0, s);
    check("no_early_valid", 32'(valid), 32'd0);
    conv(3, 41, 1'b0, s);
    check_pub("avg1", 25, 10, 41);
    step();
    check("valid_pulse", 32'(valid), 32'd0);

    // ---- timeout: no i_done; overrun also fires as TIMEOUT > SAMPLE_DIV ------
    wait_start(s1);
    repeat (TO) step();
    check("timeout_not_early", 32'(to_err), 32'd0);
    step();
    check("timeout_set", 32'(to_err), 32'd1);
    check("timeout_ovr", 32'(ovr), 32'd1);
    clr_err = 1'b1; step(); clr_err = 1'b0;
    check("clr_err_to",  32'(to_err), 32'd0);
    check("clr_err_ovr", 32'(ovr),    32'd0);
    // Ticks at s1+9 and s1+19 fall in CONVERT; next tick s1+29, start s1+30.
    conv(3, 100, 1'b0, s2);
    check("start_after_timeout", s2 - s1, 3 * SD);
    conv(3, 100, 1'b0, s);
    conv(3, 100, 1'b0, s);
    check("timeout_count_kept", 32'(valid), 32'd0);
    conv(3, 104, 1'b0, s);
    check_pub("avg2", 101, 10, 104);
    step();

    // ---- overrun: late done still accepted, tick not queued ------------------
    check("ovr_clear_before", 32'(ovr), 32'd0);
    conv(15, 50, 1'b0, s1);
    check("overrun_set", 32'(ovr), 32'd1);
    conv(3, 60, 1'b0, s2);
    check("overrun_not_queued", s2 - s1, 2 * SD);
    conv(3, 70, 1'b0, s);
    conv(3, 80, 1'b0, s);
    check_pub("avg3", 65, 10, 104);
    clr_err = 1'b1; step(); clr_err = 1'b0;
    check("ovr_cleared", 32'(ovr), 32'd0);

    // ---- hold: block of 200s is consumed but not published -------------------
    hold = 1'b1;
    repeat (4) conv(3, 200, 1'b0, s);
    check("hold_valid", 32'(valid), 32'd0);
    check("hold_avg",   32'(avg),   32'd65);
    check("hold_min",   32'(mn),    32'd10);
    check("hold_max",   32'(mx),    32'd104);
    hold = 1'b0;
    conv(3, 4, 1'b0, s);
    conv(3, 4, 1'b0, s);
    conv(3, 4, 1'b0, s);
    conv(3, 8, 1'b0, s);
    check_pub("avg_after_hold", 5, 4, 104);

    // ---- min/max clear ---------------------------------------------------------
    conv(3, 77, 1'b1, s);
    check("clr_with_sample_min", 32'(mn), 32'd77);
    check("clr_with_sample_max", 32'(mx), 32'd77);
    clr_mm = 1'b1; step(); clr_mm = 1'b0;
    check("clr_alone_min", 32'(mn), 32'hFF);
    check("clr_alone_max", 32'(mx), 32'd0);
    conv(3, 90, 1'b0, s);
    conv(3, 80, 1'b0, s);
    conv(3, 70, 1'b0, s);
    check_pub("avg_after_clr", 79, 70, 90);

    // ---- disable mid-block: partial sum of two 99s must be dropped -----------
    conv(3, 99, 1'b0, s);
    conv(3, 99, 1'b0, s);
    en = 1'b0;
    repeat (5) step();
    en = 1'b1;
    c0 = cyc;
    wait_start(s1);
    check("reenable_latency", s1 - c0, SD + 1);
    conv(3, 8, 1'b0, s);
    conv(3, 8, 1'b0, s);
    check("no_stale_count", 32'(valid), 32'd0);
    conv(3, 8, 1'b0, s);
    conv(3, 8, 1'b0, s);
    check_pub("avg_after_disable", 8, 8, 99);

    // ---- late i_done after abandoning a conversion is ignored ----------------
    wait_start(s);
    step();
    en = 1'b0;
    step();
    done = 1'b1; data = 8'd1; step(); done = 1'b0; data = 8'h00;
    en = 1'b1;
    step();
    check("late_done_ignored", 32'(mn), 32'd8);

    // ---- reset mid-CONVERT, with i_done asserted alongside -------------------
    wait_start(s);
    repeat (12) step();
    check("ovr_before_reset", 32'(ovr), 32'd1);
    rst = 1'b1; done = 1'b1; data = 8'd3;
    step();
    rst = 1'b0; done = 1'b0; data = 8'h00;
    check("mid_rst_start", 32'(start),  32'd0);
    check("mid_rst_valid", 32'(valid),  32'd0);
    check("mid_rst_avg",   32'(avg),    32'd0);
    check("mid_rst_min",   32'(mn),     32'hFF);
    check("mid_rst_max",   32'(mx),     32'd0);
    check("mid_rst_toerr", 32'(to_err), 32'd0);
    check("mid_rst_ovr",   32'(ovr),    32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
